// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and byte-count helper for the byte-serial memory access unit
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Number of memory bytes touched by a request; illegal sizes touch none
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SIZE_BYTE ? 3'd1 :
               size == SIZE_HALF ? 3'd2 :
               size == SIZE_WORD ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: sign- or zero-extends captured load bytes to XLEN according to the access size
module load_extend
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] value
);

    logic sign_bit;

    assign sign_bit = !is_unsigned && (size == SIZE_BYTE ? data[7] : data[15]);

    assign value = size == SIZE_BYTE ? {{(XLEN-8){sign_bit}}, data[7:0]} :
                   size == SIZE_HALF ? {{(XLEN-16){sign_bit}}, data[15:0]} : data;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: serialises byte/half/word loads and stores into one little-endian byte access per cycle.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned halfword/word requests instead of performing them.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_write_data,
    input  logic [7:0]            mem_read_data
);

    state_t                state;
    logic [1:0]            count;
    logic [XLEN-1:0]       data;
    logic                  write;
    logic [1:0]            size;
    logic                  is_unsigned;
    logic [ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]       wdata;
    logic                  error;
    logic                  reject;
    logic                  last;
    logic [XLEN-1:0]       load_value;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign reject = req_size == SIZE_ILLEGAL ||
                    (req_size == SIZE_HALF && req_addr[0]) ||
                    (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
`else
    assign reject = req_size == SIZE_ILLEGAL;
`endif

    assign last = {1'b0, count} == size_bytes(size) - 3'd1;

    // Request capture, byte sequencing and load-byte collection
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            data        <= '0;
            write       <= 1'b0;
            size        <= SIZE_BYTE;
            is_unsigned <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            error       <= 1'b0;
        end else if (state == IDLE) begin
            if (req_valid) begin
                write       <= req_write;
                size        <= req_size;
                is_unsigned <= req_unsigned;
                addr        <= req_addr;
                wdata       <= req_wdata;
                error       <= reject;
                count       <= '0;
                data        <= '0;
                state       <= reject ? RESP : ACCESS;
            end
        end else if (state == ACCESS) begin
            if (!write)
                data[8*count +: 8] <= mem_read_data;
            count <= count + 2'd1;
            if (last)
                state <= RESP;
        end else begin
            state <= IDLE;
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data        (data),
        .size        (size),
        .is_unsigned (is_unsigned),
        .value       (load_value)
    );

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_error = resp_valid && error;
    assign resp_rdata = resp_valid && !write && !error ? load_value : '0;

    // Memory port is idle-zero outside ACCESS; writes are suppressed during a reset cycle
    assign mem_write_enable = state == ACCESS && write && !rst;
    assign mem_addr         = state == ACCESS ? addr + ADDR_WIDTH'(count) : '0;
    assign mem_write_data   = state == ACCESS && write ? wdata[8*count +: 8] : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-array memory, random traffic and a reference model
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          preload = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_write_data;
    logic [7:0]    mem_read_data;

    logic [7:0] mem [32];
    logic [7:0] pre [32];
    logic [7:0] ref_mem [32];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    mem_access_unit #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= pre[i];
        end else if (mem_write_enable) begin
            mem[mem_addr] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: what a request should return, and its effect on memory
    function automatic exp_t model(input logic w, input logic [1:0] s, input logic u,
                                   input logic [4:0] a, input logic [31:0] wd, input int c);
        exp_t        e;
        int          n;
        logic        bad;
        logic [31:0] v;
        n   = s == 2'd0 ? 1 : s == 2'd1 ? 2 : s == 2'd2 ? 4 : 0;
        bad = s == 2'd3;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if ((s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)) bad = 1'b1;
`endif
        v       = 0;
        e.err   = bad;
        e.rdata = 0;
        e.due   = c + (bad ? 1 : n + 1);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                if (w) ref_mem[(int'(a) + i) % 32] = wd[8*i +: 8];
                else   v = v + ({24'b0, ref_mem[(int'(a) + i) % 32]} << (8 * i));
            end
            if (!w) begin
                if (!u && n == 1 && v >= 128)   v = v - 256;
                if (!u && n == 2 && v >= 32768) v = v - 65536;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic junk();
        req_valid    = 1'($urandom_range(0, 1));
        req_write    = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = 5'($urandom_range(0, 31));
        req_wdata    = $urandom;
    endtask

    task automatic quiet(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic u,
                         input logic [4:0] a, input logic [31:0] wd);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            junk();
            @(negedge clk);
            waited++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = s;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        exp_q.push_back(model(w, s, u, a, wd, cyc));
        @(negedge clk);
        junk();
    endtask

    // Monitor: compare every response against the scoreboard, and the idle bus against zero
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", {31'b0, resp_error}, {31'b0, e.err});
                check("resp_cycle", cyc, e.due);
            end
        end
        if (!rst && req_ready)
            check("idle_mem_bus", {18'b0, mem_write_enable, mem_addr, mem_write_data}, 32'd0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd;
        int          r;
        for (int i = 0; i < 32; i++) pre[i] = 8'($urandom);
        pre[4] = 8'h80;
        for (int i = 0; i < 32; i++) ref_mem[i] = pre[i];
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
        check("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'b0, mem_write_data}, 32'd0);
        rst     = 1'b0;
        preload = 1'b0;
        quiet(2);

        issue(1'b0, 2'd0, 1'b0, 5'd4, 32'd0);
        issue(1'b0, 2'd0, 1'b1, 5'd4, 32'd0);
        issue(1'b1, 2'd2, 1'b0, 5'd8, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 5'd8, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 5'd31, 32'h00001234);
        issue(1'b0, 2'd1, 1'b0, 5'd31, 32'd0);
        issue(1'b1, 2'd3, 1'b0, 5'd3, 32'hA5A5A5A5);
        issue(1'b0, 2'd2, 1'b0, 5'd2, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 5'd4, 32'd0);
        issue(1'b1, 2'd2, 1'b0, 5'd30, 32'h0BADF00D);
        issue(1'b0, 2'd2, 1'b1, 5'd30, 32'd0);

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 7);
            issue(1'($urandom_range(0, 1)),
                  r < 2 ? 2'd0 : r < 4 ? 2'd1 : r < 7 ? 2'd2 : 2'd3,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end

        quiet(1);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);

        // Store word @16 aborted by reset while its third byte is on the bus
        while (!req_ready) @(negedge clk);
        wd           = $urandom;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 5'd16;
        req_wdata    = wd;
        ref_mem[16]  = wd[7:0];
        ref_mem[17]  = wd[15:8];
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_third_byte_addr", {27'b0, mem_addr}, 32'd18);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        quiet(4);

        for (int i = 0; i < 32; i++) check($sformatf("mem[%0d]", i), {24'b0, mem[i]}, {24'b0, ref_mem[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
